// File: rtl/scratchpad_arb_pkg.sv
// Shared types and default constants for the scratchpad port arbiter.
package scratchpad_arb_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_MEM_AW       = 16;
  localparam int unsigned DEF_DATA_W       = 64;
  localparam int unsigned DEF_STARVE_LIMIT = 8;
  localparam int unsigned STARVE_CNT_W     = 8;

  typedef enum logic {
    P0_PRIO = 1'b0,
    P1_PRIO = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_idx_e;

endpackage

// File: rtl/scratchpad_port_arbiter_if.sv
// Request/response and memory-side signal bundle for the scratchpad arbiter.
interface scratchpad_port_arbiter_if
  import scratchpad_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned MEM_AW = DEF_MEM_AW,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_write;
  logic [ADDR_W-1:0]     req0_addr;
  logic [DATA_W-1:0]     req0_wdata;
  logic [DATA_W/8-1:0]   req0_mask;
  logic                  rsp0_valid;
  logic [DATA_W-1:0]     rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_write;
  logic [ADDR_W-1:0]     req1_addr;
  logic [DATA_W-1:0]     req1_wdata;
  logic [DATA_W/8-1:0]   req1_mask;
  logic                  rsp1_valid;
  logic [DATA_W-1:0]     rsp1_rdata;

  logic                  mem_en;
  logic                  mem_write;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_mask;
  logic [DATA_W-1:0]     mem_rdata;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_mask,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_mask,
    input  mem_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_en, mem_write, mem_addr, mem_wdata, mem_mask
  );

  // Requesters plus memory
  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_mask,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_mask,
    output mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_en, mem_write, mem_addr, mem_wdata, mem_mask
  );

endinterface

// File: rtl/scratchpad_arb_starve_ctrl.sv
// Port-1 starvation counter and the priority FSM it drives.
module scratchpad_arb_starve_ctrl
  import scratchpad_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rstn,
  input  logic req1_valid,
  input  logic req1_ready,
  output logic p1_prio
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT    = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] LIMIT_M1 = STARVE_CNT_W'(STARVE_LIMIT - 1);

  arb_state_e              state;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    denied;
  logic [STARVE_CNT_W-1:0] cnt_inc;

  assign denied  = req1_valid && !req1_ready;
  assign cnt_inc = (starve_cnt < LIMIT) ? starve_cnt + 1'b1 : starve_cnt;

  // Priority flips on the same edge the count reaches the limit, so the
  // next cycle already favours port 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= P0_PRIO;
      starve_cnt <= '0;
      p1_prio    <= 1'b0;
    end else begin
      case (state)
        P0_PRIO: begin
          if (denied) begin
            starve_cnt <= cnt_inc;
            if (starve_cnt >= LIMIT_M1) begin
              state   <= P1_PRIO;
              p1_prio <= 1'b1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        P1_PRIO: begin
          if (!req1_valid || req1_ready) begin
            state      <= P0_PRIO;
            p1_prio    <= 1'b0;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= cnt_inc;
          end
        end
        default: begin
          state      <= P0_PRIO;
          p1_prio    <= 1'b0;
          starve_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/scratchpad_port_arbiter.sv
// Two-port scratchpad arbiter: zero-latency grant mux, starvation-based
// priority swap, and one-deep tagged read-response routing.
module scratchpad_port_arbiter
  import scratchpad_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned MEM_AW       = DEF_MEM_AW,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                      clk,
  input  logic                      rstn,
  scratchpad_port_arbiter_if.slave  bus,
  output logic                      starve_active
);

  localparam int unsigned MASK_W = DATA_W / 8;

  logic              p1_prio;
  logic              xfer;
  port_idx_e         gnt_port;
  logic              sel_write;
  logic [MEM_AW-1:0] sel_word;
  logic [DATA_W-1:0] sel_wdata;
  logic [MASK_W-1:0] sel_mask;

  logic [MEM_AW-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;
  logic              rsp_pend;
  port_idx_e         rsp_port;

  scratchpad_arb_starve_ctrl #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rstn       (rstn),
    .req1_valid (bus.req1_valid),
    .req1_ready (bus.req1_ready),
    .p1_prio    (p1_prio)
  );

  assign starve_active = p1_prio;

  // Readies are gated by rstn so every output is quiet while in reset.
  assign bus.req0_ready = rstn && bus.req0_valid && (!bus.req1_valid || !p1_prio);
  assign bus.req1_ready = rstn && bus.req1_valid && (!bus.req0_valid ||  p1_prio);

  assign xfer     = bus.req0_ready || bus.req1_ready;
  assign gnt_port = bus.req1_ready ? PORT1 : PORT0;

  always_comb begin
    sel_write = bus.req0_write;
    sel_word  = bus.req0_addr[MEM_AW+2:3];
    sel_wdata = bus.req0_wdata;
    sel_mask  = bus.req0_mask;
    if (gnt_port == PORT1) begin
      sel_write = bus.req1_write;
      sel_word  = bus.req1_addr[MEM_AW+2:3];
      sel_wdata = bus.req1_wdata;
      sel_mask  = bus.req1_mask;
    end
  end

  // Idle cycles replay the last granted fields to avoid bus toggling.
  assign bus.mem_en    = xfer;
  assign bus.mem_write = xfer && sel_write;
  assign bus.mem_addr  = xfer ? sel_word  : addr_q;
  assign bus.mem_wdata = xfer ? sel_wdata : wdata_q;
  assign bus.mem_mask  = xfer ? sel_mask  : mask_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rsp_pend <= 1'b0;
      rsp_port <= PORT0;
    end else begin
      rsp_pend <= xfer && !sel_write;
      if (xfer) begin
        addr_q   <= sel_word;
        wdata_q  <= sel_wdata;
        mask_q   <= sel_mask;
        rsp_port <= gnt_port;
      end
    end
  end

  assign bus.rsp0_valid = rsp_pend && (rsp_port == PORT0);
  assign bus.rsp1_valid = rsp_pend && (rsp_port == PORT1);
  assign bus.rsp0_rdata = bus.rsp0_valid ? bus.mem_rdata : '0;
  assign bus.rsp1_rdata = bus.rsp1_valid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// Scoreboard bench for scratchpad_port_arbiter with a registered memory model.
module tb_scratchpad_port_arbiter;

  logic clk;
  logic rstn;
  logic starve_active;
  logic starve_active2;
  int unsigned cyc;
  int checks;
  int errors;

  typedef struct {
    logic        port;
    logic [63:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [63:0] mem [0:255];
  logic [63:0] mem_rdata_q;

  scratchpad_port_arbiter_if #(.ADDR_W(32), .MEM_AW(16), .DATA_W(64)) bus ();
  scratchpad_port_arbiter_if #(.ADDR_W(32), .MEM_AW(16), .DATA_W(64)) bus2 ();

  scratchpad_port_arbiter #(
    .ADDR_W(32), .MEM_AW(16), .DATA_W(64), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .starve_active(starve_active)
  );

  scratchpad_port_arbiter #(
    .ADDR_W(32), .MEM_AW(16), .DATA_W(64), .STARVE_LIMIT(1)
  ) dut2 (
    .clk(clk), .rstn(rstn), .bus(bus2), .starve_active(starve_active2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered memory: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 8; b++)
          if (bus.mem_mask[b]) mem[bus.mem_addr[7:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata_q <= mem[bus.mem_addr[7:0]];
      end
    end
  end
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus2.mem_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL rsp_missing port=%0d actual=none required_cycle=%0d", exp_q[0].port, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (bus.rsp0_valid || bus.rsp1_valid) begin
      if (bus.rsp0_valid && bus.rsp1_valid) check("rsp_both_valid", 64'd1, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual rsp0=%0b rsp1=%0b required none", bus.rsp0_valid, bus.rsp1_valid);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_port", 64'(bus.rsp1_valid), 64'(mon_e.port));
        check("rsp_rdata", bus.rsp1_valid ? bus.rsp1_rdata : bus.rsp0_rdata, mon_e.data);
        check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input logic port, input logic valid, input logic wr, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask);
    if (port) begin
      bus.req1_write = wr; bus.req1_addr = addr; bus.req1_wdata = wdata;
      bus.req1_mask = mask; bus.req1_valid = valid;
    end else begin
      bus.req0_write = wr; bus.req0_addr = addr; bus.req0_wdata = wdata;
      bus.req0_mask = mask; bus.req0_valid = valid;
    end
  endtask

  task automatic issue(input logic port, input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [7:0] mask, input logic [63:0] exp_rd, input bit push, input bit immediate);
    int unsigned waited;
    bit got;
    logic [31:0] a;
    waited = 0;
    got = 0;
    a = addr;
    set_req(port, 1'b1, wr, addr, wdata, mask);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? bus.req1_ready : bus.req0_ready) begin
        got = 1;
        break;
      end
      waited++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout port=%0d actual=no_ready required=ready", port);
    end else begin
      if (immediate) check("grant_latency", 64'(waited), 64'd0);
      check("other_ready", 64'(port ? bus.req0_ready : bus.req1_ready), 64'd0);
      check("mem_en", 64'(bus.mem_en), 64'd1);
      check("mem_write", 64'(bus.mem_write), 64'(wr));
      check("mem_addr", 64'(bus.mem_addr), 64'(a[18:3]));
      if (wr) begin
        check("mem_wdata", bus.mem_wdata, wdata);
        check("mem_mask", 64'(bus.mem_mask), 64'(mask));
      end else if (push) begin
        exp_q.push_back('{port, exp_rd, cyc + 1});
      end
    end
    @(posedge clk);
    #1;
    set_req(port, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                               bus.mem_en, bus.mem_write, starve_active}), 64'd0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_mem_mask"}, 64'(bus.mem_mask), 64'd0);
    check({tag, "_data"}, bus.mem_wdata | bus.rsp0_rdata | bus.rsp1_rdata, 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    mem_rdata_q = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 64'h11;
    mem[1] = 64'h22;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h8, 64'h0, 8'h0);
    bus2.req0_valid = 0; bus2.req0_write = 0; bus2.req0_addr = '0; bus2.req0_wdata = '0; bus2.req0_mask = '0;
    bus2.req1_valid = 0; bus2.req1_write = 0; bus2.req1_addr = '0; bus2.req1_wdata = '0; bus2.req1_mask = '0;
    rstn = 1'b0;
    bus.req0_valid = 1'b1;

    // Outputs held low in reset even with both requests pending
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_starve_cnt", 64'(dut.u_starve.starve_cnt), 64'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Release with a pending read: granted on the first cycle
    @(posedge clk); #1;
    rstn = 1'b1;
    issue(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 64'h11, 1, 1);

    // Write then read back on port 0
    issue(1'b0, 1'b1, 32'h80, 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'h0, 0, 1);
    @(negedge clk);
    check("idle_mem_en_write", 64'({bus.mem_en, bus.mem_write}), 64'd0);
    check("idle_mem_addr_hold", 64'(bus.mem_addr), 64'h10);
    check("idle_mem_mask_hold", 64'(bus.mem_mask), 64'hFF);
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'h80, 64'h0, 8'h0, 64'hDEAD_BEEF_0123_4567, 1, 1);

    // Back-to-back alternating reads
    issue(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 64'h11, 1, 1);
    issue(1'b1, 1'b0, 32'h8, 64'h0, 8'h0, 64'h22, 1, 1);
    issue(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 64'h11, 1, 1);
    issue(1'b1, 1'b0, 32'h8, 64'h0, 8'h0, 64'h22, 1, 1);

    // Continuous contention: 8 grants to port 0, then one to port 1
    set_req(1'b0, 1'b1, 1'b0, 32'h0, 64'h0, 8'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h8, 64'h0, 8'h0);
    for (int i = 0; i < 27; i++) begin
      logic e1;
      @(negedge clk);
      e1 = ((i % 9) == 8);
      check("contend_grant_starve", 64'({bus.req0_ready, bus.req1_ready, starve_active}),
            64'({~e1, e1, e1}));
      exp_q.push_back('{e1, e1 ? 64'h22 : 64'h11, cyc + 1});
      @(posedge clk); #1;
    end
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    @(negedge clk);
    check("post_contend_state", 64'({starve_active, dut.u_starve.starve_cnt}), 64'd0);
    @(posedge clk); #1;

    // Port 1 starved 5 cycles, then withdraws
    set_req(1'b0, 1'b1, 1'b0, 32'h0, 64'h0, 8'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h8, 64'h0, 8'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("starve5_grant", 64'({bus.req0_ready, bus.req1_ready}), 64'b10);
      check("starve5_cnt", 64'(dut.u_starve.starve_cnt), 64'(i));
      exp_q.push_back('{1'b0, 64'h11, cyc + 1});
      @(posedge clk); #1;
    end
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    @(negedge clk);
    check("starve5_cnt_peak", 64'(dut.u_starve.starve_cnt), 64'd5);
    exp_q.push_back('{1'b0, 64'h11, cyc + 1});
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    @(negedge clk);
    check("starve5_cnt_clear", 64'(dut.u_starve.starve_cnt), 64'd0);
    check("starve5_state_p0", 64'(starve_active), 64'd0);
    @(posedge clk); #1;

    // Port-1 partial write: no response expected
    issue(1'b1, 1'b1, 32'h8, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 64'h0, 0, 1);
    @(negedge clk);
    check("p1_write_mem_hi", mem[1][63:32], 64'h0);
    check("p1_write_mem_lo", mem[1][31:0], 64'hCCCC_DDDD);
    @(posedge clk); #1;

    // Reset the cycle after a read is accepted: its response is dropped
    issue(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 64'h11, 0, 1);
    rstn = 1'b0;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    issue(1'b0, 1'b0, 32'h8, 64'h0, 8'h0, 64'hCCCC_DDDD, 1, 1);

    // STARVE_LIMIT = 1 instance alternates under contention
    bus2.req0_valid = 1'b1;
    bus2.req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("limit1_alternate", 64'({bus2.req0_ready, bus2.req1_ready}), (i % 2) ? 64'b01 : 64'b10);
      @(posedge clk); #1;
    end
    bus2.req0_valid = 1'b0;
    bus2.req1_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scratchpad_port_arbiter.md
SCRATCHPAD_PORT_ARBITER -- requirements
Module: scratchpad_port_arbiter

Interface
REQ-001 Parameters SHALL be:
  - ADDR_W, default 32, request byte-address width.
  - MEM_AW, default 16, memory word-address width.
  - DATA_W, default 64, data width.
  - STARVE_LIMIT, default 8, number of consecutive denied cycles before port 1 gets priority; legal range 1..255.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
  - clk  in  1  sole clock; all state rises on posedge.
  - rstn  in  1  asynchronous active-low reset.
  - reqN_valid  in  1  request valid, N = 0 (core port), 1 (backdoor/loader port).
  - reqN_ready  out  1  request accepted this cycle.
  - reqN_write  in  1  1 = write, 0 = read.
  - reqN_addr  in  ADDR_W  byte address.
  - reqN_wdata  in  DATA_W  write data.
  - reqN_mask  in  DATA_W/8  byte-enable mask.
  - rspN_valid  out  1  read data valid.
  - rspN_rdata  out  DATA_W  read data.
  - mem_en  out  1  memory access strobe.
  - mem_write  out  1  memory write enable.
  - mem_addr  out  MEM_AW  word address.
  - mem_wdata  out  DATA_W  write data.
  - mem_mask  out  DATA_W/8  byte enables.
  - mem_rdata  in  DATA_W  registered read data, valid one cycle after mem_en with mem_write = 0.
  - starve_active  out  1  high while the FSM is in P1_PRIO.

Function
REQ-003 Handshake: a request transfers on a cycle where reqN_valid && reqN_ready; at most one ready is high per cycle; ready is combinational from valid and the FSM state.
REQ-004 A requester SHALL hold all reqN_* inputs stable while valid && !ready; the arbiter does not register request fields.
REQ-005 On a transfer cycle, mem_en = 1 and mem_write/mem_wdata/mem_mask are muxed from the granted port in the same cycle (zero added latency).
REQ-006 mem_addr = reqN_addr[MEM_AW+2:3]; the low 3 address bits are ignored and higher bits truncated.
REQ-007 With no transfer, mem_en = 0 and mem_write = 0; other mem_* outputs hold the last driven value (no toggling).
REQ-008 For an accepted read, rspN_valid SHALL pulse exactly one cycle later with rspN_rdata = mem_rdata; writes produce no response; responses have no backpressure.
REQ-009 Back-to-back reads, same or alternating ports: one per cycle, responses in issue order, routed via a 1-entry registered port tag.
REQ-010 FSM states:
  - P0_PRIO (reset state): both valid -> port 0 granted.
  - P1_PRIO: both valid -> port 1 granted.
REQ-011 starve_cnt (8 bits) increments each cycle req1_valid && !req1_ready, saturating at STARVE_LIMIT; it clears on a port-1 transfer or when req1_valid = 0.
REQ-012 Transition P0_PRIO -> P1_PRIO on the cycle after starve_cnt reaches STARVE_LIMIT.
REQ-013 Transition P1_PRIO -> P0_PRIO on the cycle after a port-1 transfer or when req1_valid drops; entering P0_PRIO clears starve_cnt.
REQ-014 A single valid requester SHALL be granted in either state (no idle bubbles).
REQ-015 STARVE_LIMIT = 1: under continuous contention the grants alternate port0, port1, port0, port1.

Reset
REQ-016 While rstn = 0, all outputs SHALL be 0, FSM = P0_PRIO, starve_cnt = 0, and the response tag is invalid.
REQ-017 Reset asserted mid-read SHALL drop the pending response: no rspN_valid after rstn rises.
REQ-018 On the first cycle after rstn rises, a pending request SHALL be grantable.

Structure
REQ-019 A shared package (scratchpad_arb_pkg) SHALL hold the FSM state enum, the port-index type and default parameter constants.
REQ-020 The starvation counter plus its priority FSM SHALL be one sub-module, scratchpad_arb_starve_ctrl; the muxing and response routing stay in the top module.

Verification
REQ-021 Port-0 write addr 0x80, data 0xDEAD_BEEF_0123_4567, mask 0xFF, then port-0 read of 0x80: rsp0_valid one cycle after the read is accepted, rdata 0xDEAD_BEEF_0123_4567, rsp1_valid stays 0.
REQ-022 Both ports assert read valid continuously, STARVE_LIMIT = 8: port 0 granted 8 cycles, then port 1 granted once, starve_active high exactly during P1_PRIO, then the pattern repeats.
REQ-023 Alternating reads port0 addr 0x0, port1 addr 0x8, with the memory model preloaded 0x11 and 0x22: rsp0 = 0x11 and rsp1 = 0x22, each exactly one cycle after its grant.
REQ-024 Port-1 write of 0x8 with mask 0x0F: mem_mask = 0x0F and mem_addr = 0x1 on the grant cycle; no rsp pulse.
REQ-025 rstn pulled low the cycle after a port-0 read is accepted: rsp0_valid never asserts, all outputs read 0 during reset, and the first request after release is granted immediately.
REQ-026 Port 1 starved for 5 cycles then drops req1_valid: starve_cnt returns to 0 and the FSM stays in P0_PRIO.
